// File: rtl/reliability_pkg.sv
// Shared parameters, state encoding and helpers for the reliability datapath.
// Imported by the combiner, encoder and stochastic decoder.
package reliability_pkg;

    localparam int LANES_DEF         = 8;
    localparam int WINDOW_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dec_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational ones counter over a LANES-bit word.
// Pairwise adder tree, folding neighbours at doubling strides.
module popcount8
    import reliability_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int CW    = clog2(LANES + 1)
) (
    input  logic [LANES-1:0] bits_i,
    output logic [CW-1:0]    count_o
);

    logic [CW-1:0] s [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s[i] = CW'(bits_i[i]);
        end
        for (int st = 1; st < LANES; st = st * 2) begin
            for (int i = 0; i + st < LANES; i = i + 2 * st) begin
                s[i] = s[i] + s[i + st];
            end
        end
        count_o = s[0];
    end

endmodule

// File: rtl/stochastic_decoder.sv
// Windowed ones-counter turning a LANES-wide stochastic stream into a
// Q0.OUT_W probability, held in a one-deep valid/ready output register.
module stochastic_decoder
    import reliability_pkg::*;
#(
    parameter int LANES         = LANES_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int OUT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_bits,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_prob
);

    localparam int TOTAL = LANES * WINDOW_CYCLES;
    localparam int AW    = clog2(TOTAL + 1);
    localparam int PW    = clog2(LANES + 1);
    localparam int BWR   = clog2(WINDOW_CYCLES);
    localparam int BW    = (BWR > 0) ? BWR : 1;
    localparam int SHIFT = clog2(TOTAL) - OUT_W;
    localparam int MAXV  = (2 ** OUT_W) - 1;

    localparam logic [BW-1:0] LAST = BW'(WINDOW_CYCLES - 1);

    dec_state_e        state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]  prob_q, prob_d;
    logic [PW-1:0]     pop;
    logic [AW-1:0]     sum;
    logic [AW-1:0]     shifted;
    logic [OUT_W-1:0]  sat;

    popcount8 #(
        .LANES (LANES),
        .CW    (PW)
    ) u_pop (
        .bits_i  (in_bits),
        .count_o (pop)
    );

    assign sum     = acc_q + AW'(pop);
    assign shifted = sum >> SHIFT;
    // A full all-ones window overflows OUT_W bits by one; clamp it.
    assign sat = (shifted > AW'(MAXV)) ? OUT_W'(MAXV)
                                       : shifted[OUT_W-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prob_d  = prob_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = cnt_q;
                        prob_d  = sat;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            prob_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prob_q  <= prob_d;
        end
    end

    assign busy      = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_prob  = prob_q;

endmodule

// File: tb/tb_stochastic_decoder.sv
// Self-checking bench for stochastic_decoder: directed window table,
// hand-written hold/reset/restart sequences and random windows.
module tb_stochastic_decoder;

    localparam int LANES  = 8;
    localparam int WIN    = 32;
    localparam int OUT_W  = 8;
    localparam int TOTAL  = LANES * WIN;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [LANES-1:0] in_bits = '0;
    logic             busy;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_prob;

    int tests = 0;
    int fails = 0;

    logic [7:0] beats [WIN];

    typedef struct {
        string      name;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         stall;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    stochastic_decoder #(
        .LANES         (LANES),
        .WINDOW_CYCLES (WIN),
        .OUT_W         (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prob  (out_prob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: fraction of ones in the window scaled to OUT_W bits.
    function automatic logic [7:0] model(input int ones);
        int v;
        v = (ones * (2 ** OUT_W)) / TOTAL;
        if (v > (2 ** OUT_W) - 1) v = (2 ** OUT_W) - 1;
        return 8'(v);
    endfunction

    function automatic int ones_in_window();
        int n;
        n = 0;
        for (int i = 0; i < WIN; i++) n += $countones(beats[i]);
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input bit stall, input logic [7:0] exp,
                        input string name);
        for (int i = 0; i < WIN; i++) begin
            if (stall && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_bits  = 8'hFF;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_bits  = beats[i];
            @(negedge clk);
            in_valid = 1'b0;
            if (i == WIN - 2) begin
                chk({name, " early_valid"}, 32'(out_valid), 0);
                chk({name, " busy"}, 32'(busy), 1);
            end
        end
        chk({name, " valid"}, 32'(out_valid), 1);
        chk({name, " prob"}, 32'(out_prob), 32'(exp));
        chk({name, " busy_done"}, 32'(busy), 0);
    endtask

    task automatic hold_and_drain(input int hold, input logic [7:0] exp,
                                  input string name);
        for (int c = 0; c < hold; c++) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_bits  = 8'($urandom);
            @(negedge clk);
            chk({name, " hold_valid"}, 32'(out_valid), 1);
            chk({name, " hold_prob"}, 32'(out_prob), 32'(exp));
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " drained"}, 32'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{"all_ones",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF};
        vecs[1] = '{"all_zeros", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{"alt_f0_0f", 8'hF0, 8'h0F, 8'hF0, 8'h0F, 1'b0, 8'h80};
        vecs[3] = '{"half_stall",8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h80};
        vecs[4] = '{"nibbles",   8'h0F, 8'h0F, 8'h0F, 8'h0F, 1'b0, 8'h80};
        vecs[5] = '{"quarter",   8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h40};

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset prob", 32'(out_prob), 0);
        rst = 1'b0;

        in_valid = 1'b1;
        in_bits  = 8'hFF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle ignores beats", 32'(busy), 0);

        foreach (vecs[k]) begin
            for (int i = 0; i < WIN; i++) begin
                if (i < WIN / 2) beats[i] = (i % 2 == 0) ? vecs[k].a0 : vecs[k].a1;
                else             beats[i] = (i % 2 == 0) ? vecs[k].b0 : vecs[k].b1;
            end
            pulse_start();
            feed(vecs[k].stall, vecs[k].exp, vecs[k].name);
            hold_and_drain((k == 2) ? 10 : 0, vecs[k].exp, vecs[k].name);
            chk({vecs[k].name, " idle"}, 32'(busy), 0);
        end

        // Asynchronous reset mid-window after a nonzero result was held.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_bits  = 8'hFF;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy), 0);
        chk("async rst valid", 32'(out_valid), 0);
        chk("async rst prob", 32'(out_prob), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIN; i++) beats[i] = 8'h0F;
        pulse_start();
        feed(1'b0, 8'h80, "post_rst");
        hold_and_drain(0, 8'h80, "post_rst");

        // Restart at beat 10: the restart-cycle beat is discarded too.
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_bits  = 8'hFF;
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("restart busy", 32'(busy), 1);
        for (int i = 0; i < WIN; i++) beats[i] = 8'h00;
        feed(1'b0, 8'h00, "restart");
        hold_and_drain(0, 8'h00, "restart");

        for (int r = 0; r < 8; r++) begin
            int   n;
            logic [7:0] e;
            bit   st;
            for (int i = 0; i < WIN; i++) beats[i] = 8'($urandom);
            if (r == 0) for (int i = 0; i < WIN; i++) beats[i] = beats[i] | 8'hFE;
            n  = ones_in_window();
            e  = model(n);
            st = 1'($urandom_range(0, 1));
            pulse_start();
            feed(st, e, $sformatf("rand%0d", r));
            hold_and_drain(int'($urandom_range(0, 3)), e, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
